// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 set-2 keyboard deframer, prefix decoder and pressed-key map
module ps2_key_decoder #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ps2_clk,
    input  logic         ps2_data,
    output logic [511:0] key_down,
    output logic [8:0]   last_change,
    output logic         been_ready,
    output logic         frame_err
);

    // The timeout counter must be able to reach TIMEOUT_CYCLES-1.
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    // Bit positions within the 11-bit frame, as counted by bit_cnt.
    localparam logic [3:0] BIT_START  = 4'd0;
    localparam logic [3:0] BIT_D7     = 4'd8;
    localparam logic [3:0] BIT_PARITY = 4'd9;
    localparam logic [3:0] BIT_STOP   = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_E0,
        ST_F0,
        ST_E0F0
    } pfx_state_t;

    // Synchronizer chains; both pins idle high so reset to all ones.
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   ps2_clk_s;
    logic                   ps2_data_s;
    logic                   fall;

    // Deframer state.
    logic [3:0]      bit_cnt;
    logic [7:0]      rx_byte;
    logic            parity_bit;
    logic [TO_W-1:0] to_cnt;
    logic            byte_valid;

    // Prefix decoder.
    pfx_state_t state;
    pfx_state_t state_next;
    logic       evt_valid;
    logic       evt_break;
    logic [8:0] evt_code;

    assign ps2_clk_s  = clk_sync[SYNC_STAGES-1];
    assign ps2_data_s = data_sync[SYNC_STAGES-1];
    assign fall       = clk_prev & ~ps2_clk_s;

    // Bring the asynchronous pins into the clk domain and remember the last clock level.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= ps2_clk_s;
        end
    end

    // Shift in one frame bit per falling edge; validate parity/stop; abandon stalled frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt    <= BIT_START;
            rx_byte    <= 8'h00;
            parity_bit <= 1'b0;
            to_cnt     <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall) begin
                to_cnt <= '0;
                if (bit_cnt == BIT_START) begin
                    // A high start bit is line noise or a glitch: stay idle silently.
                    if (!ps2_data_s) begin
                        bit_cnt <= 4'd1;
                    end
                end else if (bit_cnt <= BIT_D7) begin
                    // Data arrives LSB first, so shift in from the top.
                    rx_byte <= {ps2_data_s, rx_byte[7:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end else if (bit_cnt == BIT_PARITY) begin
                    parity_bit <= ps2_data_s;
                    bit_cnt    <= BIT_STOP;
                end else begin
                    // Stop bit: odd parity over data+parity and a high stop bit required.
                    bit_cnt <= BIT_START;
                    if (ps2_data_s && ((^rx_byte) ^ parity_bit)) begin
                        byte_valid <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
            end else if (bit_cnt != BIT_START) begin
                // Mid-frame with no edge: count towards the stall limit.
                if (to_cnt == TO_LAST) begin
                    frame_err <= 1'b1;
                    bit_cnt   <= BIT_START;
                    to_cnt    <= '0;
                end else begin
                    to_cnt <= to_cnt + TO_W'(1);
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

    // Prefix state register; only complete good bytes move it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Classify each received byte as prefix, ignored control byte, or key event.
    always_comb begin
        state_next = state;
        evt_valid  = 1'b0;
        evt_break  = 1'b0;
        evt_code   = 9'd0;
        if (byte_valid) begin
            case (rx_byte)
                8'hE0: begin
                    state_next = ST_E0;
                end
                8'hF0: begin
                    case (state)
                        ST_IDLE: state_next = ST_F0;
                        ST_E0:   state_next = ST_E0F0;
                        default: state_next = state;
                    endcase
                end
                8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF, 8'hE1: begin
                    // Keyboard status/response bytes: drop any pending prefix.
                    state_next = ST_IDLE;
                end
                default: begin
                    evt_valid  = 1'b1;
                    evt_break  = (state == ST_F0) || (state == ST_E0F0);
                    evt_code   = {(state == ST_E0) || (state == ST_E0F0), rx_byte};
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Apply a make/break to the key map and publish it one cycle after the byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_down    <= '0;
            last_change <= 9'd0;
            been_ready  <= 1'b0;
        end else begin
            been_ready <= evt_valid;
            if (evt_valid) begin
                key_down[evt_code] <= ~evt_break;
                last_change        <= evt_code;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - directed self-checking bench for ps2_key_decoder
module tb_ps2_key_decoder;

    localparam int HALF    = 20;
    localparam int TIMEOUT = 1000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ps2_clk = 1'b1;
    logic         ps2_data = 1'b1;
    logic [511:0] key_down;
    logic [8:0]   last_change;
    logic         been_ready;
    logic         frame_err;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_fall_cyc = 0;
    int br_cnt = 0;
    int fe_cnt = 0;
    int br_lat = -1;

    ps2_key_decoder #(
        .SYNC_STAGES(2),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .key_down(key_down),
        .last_change(last_change),
        .been_ready(been_ready),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Count pulse cycles (a stretched pulse counts twice) and latency from the last falling edge.
    always @(negedge clk) begin
        if (been_ready) begin
            br_cnt = br_cnt + 1;
            br_lat = cyc - last_fall_cyc;
        end
        if (frame_err) fe_cnt = fe_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~(^b) ^ bad_par);
        ps2_bit(~bad_stop);
        ps2_data = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        tests++;
        if (key_down !== '0 || last_change !== 9'd0 || been_ready !== 1'b0 || frame_err !== 1'b0) begin
            fails++;
            $display("FAIL reset: key_down_ones=%0d last_change=%h br=%b fe=%b required all zero",
                     $countones(key_down), last_change, been_ready, frame_err);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_make;
        int br0;
        br0 = br_cnt;
        br_lat = -1;
        send(8'h1C);
        tests++;
        if (key_down[9'h01C] !== 1'b1 || $countones(key_down) != 1) begin
            fails++;
            $display("FAIL make_map: bit=%b ones=%0d required 1/1", key_down[9'h01C], $countones(key_down));
        end
        tests++;
        if (last_change !== 9'h01C) begin
            fails++;
            $display("FAIL make_last: got %h required 01c", last_change);
        end
        tests++;
        if (br_cnt - br0 != 1) begin
            fails++;
            $display("FAIL make_pulse: got %0d cycles required 1", br_cnt - br0);
        end
        tests++;
        if (br_lat != 4) begin
            fails++;
            $display("FAIL make_latency: got %0d required 4", br_lat);
        end
    endtask

    task automatic test_break;
        int br0;
        br0 = br_cnt;
        send(8'hF0);
        send(8'h1C);
        tests++;
        if (key_down[9'h01C] !== 1'b0 || last_change !== 9'h01C || br_cnt - br0 != 1) begin
            fails++;
            $display("FAIL break: bit=%b last=%h pulses=%0d required 0/01c/1",
                     key_down[9'h01C], last_change, br_cnt - br0);
        end
    endtask

    task automatic test_extended;
        int br0;
        br0 = br_cnt;
        send(8'hE0);
        send(8'h74);
        tests++;
        if (key_down[9'h174] !== 1'b1 || key_down[9'h074] !== 1'b0 || last_change !== 9'h174) begin
            fails++;
            $display("FAIL ext_make: b174=%b b074=%b last=%h required 1/0/174",
                     key_down[9'h174], key_down[9'h074], last_change);
        end
        send(8'hE0);
        send(8'hF0);
        send(8'h74);
        tests++;
        if (key_down[9'h174] !== 1'b0 || last_change !== 9'h174 || br_cnt - br0 != 2) begin
            fails++;
            $display("FAIL ext_break: b174=%b last=%h pulses=%0d required 0/174/2",
                     key_down[9'h174], last_change, br_cnt - br0);
        end
    endtask

    task automatic test_two_keys;
        send(8'h1C);
        send(8'h23);
        send(8'hF0);
        send(8'h1C);
        tests++;
        if (key_down[9'h023] !== 1'b1 || key_down[9'h01C] !== 1'b0 || last_change !== 9'h01C) begin
            fails++;
            $display("FAIL two_keys: b023=%b b01c=%b last=%h required 1/0/01c",
                     key_down[9'h023], key_down[9'h01C], last_change);
        end
        send(8'hF0);
        send(8'h23);
    endtask

    task automatic test_typematic;
        int br0;
        br0 = br_cnt;
        send(8'h1C);
        send(8'h1C);
        tests++;
        if (br_cnt - br0 != 2 || key_down[9'h01C] !== 1'b1 || $countones(key_down) != 1) begin
            fails++;
            $display("FAIL typematic: pulses=%0d bit=%b ones=%0d required 2/1/1",
                     br_cnt - br0, key_down[9'h01C], $countones(key_down));
        end
        br0 = br_cnt;
        send(8'hF0);
        send(8'h2B);
        tests++;
        if (br_cnt - br0 != 1 || key_down[9'h02B] !== 1'b0 || last_change !== 9'h02B
            || $countones(key_down) != 1) begin
            fails++;
            $display("FAIL break_unheld: pulses=%0d bit=%b last=%h ones=%0d required 1/0/02b/1",
                     br_cnt - br0, key_down[9'h02B], last_change, $countones(key_down));
        end
        send(8'hF0);
        send(8'h1C);
    endtask

    task automatic test_ignored;
        int br0;
        br0 = br_cnt;
        send(8'hFA);
        tests++;
        if (br_cnt != br0 || last_change !== 9'h01C) begin
            fails++;
            $display("FAIL ignored_fa: pulses=%0d last=%h required 0/01c", br_cnt - br0, last_change);
        end
        send(8'hE0);
        send(8'hAA);
        send(8'h1C);
        tests++;
        if (br_cnt - br0 != 1 || key_down[9'h11C] !== 1'b0 || key_down[9'h01C] !== 1'b1) begin
            fails++;
            $display("FAIL ignored_clears_prefix: pulses=%0d b11c=%b b01c=%b required 1/0/1",
                     br_cnt - br0, key_down[9'h11C], key_down[9'h01C]);
        end
        send(8'hF0);
        send(8'h1C);
    endtask

    task automatic test_bad_parity;
        int br0;
        int fe0;
        br0 = br_cnt;
        fe0 = fe_cnt;
        send_frame(8'h1D, 1'b1, 1'b0);
        tests++;
        if (fe_cnt - fe0 != 1 || br_cnt != br0 || $countones(key_down) != 0) begin
            fails++;
            $display("FAIL bad_parity: err_pulses=%0d events=%0d ones=%0d required 1/0/0",
                     fe_cnt - fe0, br_cnt - br0, $countones(key_down));
        end
        fe0 = fe_cnt;
        send_frame(8'h1D, 1'b0, 1'b1);
        tests++;
        if (fe_cnt - fe0 != 1 || br_cnt != br0) begin
            fails++;
            $display("FAIL bad_stop: err_pulses=%0d events=%0d required 1/0", fe_cnt - fe0, br_cnt - br0);
        end
    endtask

    task automatic test_prefix_survives_error;
        send(8'h1C);
        send(8'hF0);
        send_frame(8'h33, 1'b1, 1'b0);
        send(8'h1C);
        tests++;
        if (key_down[9'h01C] !== 1'b0 || last_change !== 9'h01C) begin
            fails++;
            $display("FAIL prefix_after_err: bit=%b last=%h required 0/01c", key_down[9'h01C], last_change);
        end
    endtask

    task automatic test_start_high;
        int br0;
        int fe0;
        br0 = br_cnt;
        fe0 = fe_cnt;
        ps2_bit(1'b1);
        repeat (10) @(negedge clk);
        send(8'h1B);
        tests++;
        if (fe_cnt != fe0 || br_cnt - br0 != 1 || key_down[9'h01B] !== 1'b1 || last_change !== 9'h01B) begin
            fails++;
            $display("FAIL start_high: errs=%0d events=%0d bit=%b last=%h required 0/1/1/01b",
                     fe_cnt - fe0, br_cnt - br0, key_down[9'h01B], last_change);
        end
        send(8'hF0);
        send(8'h1B);
    endtask

    task automatic test_timeout;
        int fe0;
        fe0 = fe_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'b1);
        repeat (TIMEOUT + 200) @(negedge clk);
        tests++;
        if (fe_cnt - fe0 != 1) begin
            fails++;
            $display("FAIL timeout_err: got %0d pulses required 1", fe_cnt - fe0);
        end
        send(8'h23);
        tests++;
        if (key_down[9'h023] !== 1'b1 || last_change !== 9'h023) begin
            fails++;
            $display("FAIL timeout_recover: bit=%b last=%h required 1/023", key_down[9'h023], last_change);
        end
    endtask

    task automatic test_reset_midframe;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (key_down !== '0 || last_change !== 9'd0) begin
            fails++;
            $display("FAIL reset_mid_clear: ones=%0d last=%h required 0/000", $countones(key_down), last_change);
        end
        send(8'h2B);
        tests++;
        if (key_down[9'h02B] !== 1'b1 || $countones(key_down) != 1 || last_change !== 9'h02B) begin
            fails++;
            $display("FAIL reset_mid_next: bit=%b ones=%0d last=%h required 1/1/02b",
                     key_down[9'h02B], $countones(key_down), last_change);
        end
    endtask

    initial begin
        test_reset;
        test_make;
        test_break;
        test_extended;
        test_two_keys;
        test_typematic;
        test_ignored;
        test_bad_parity;
        test_prefix_survives_error;
        test_start_high;
        test_timeout;
        test_reset_midframe;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
